// File: rtl/core_debug_driver.sv
// core_debug_driver: stretched core reset, single-step, register dump and interrupt injection for RV32core.
// Ports: clk/rst (async active-high); mode, step_req, dump_start, irq_req, debug_data, dump_ready in;
// core_rst, debug_en, debug_step, debug_addr out to the core; dump_valid/addr/data/done dump stream;
// interrupter, irq_id interrupt line and the channel being injected.
module core_debug_driver #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int RST_CYCLES = 4,
  parameter int NUM_IRQ = 4,
  parameter int IRQ_HOLD = 3,
  parameter int DUMP_FIRST = 0,
  parameter int DUMP_LAST = 31,
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              step_req,
  input  logic              dump_start,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [DATA_W-1:0] debug_data,
  input  logic              dump_ready,
  output logic              core_rst,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic              interrupter,
  output logic [IW-1:0]     irq_id
);
  localparam logic [2:0] S_RST = 3'd0, S_RUN = 3'd1, S_HALT = 3'd2, S_STEP = 3'd3,
                         S_DADDR = 3'd4, S_DCAP = 3'd5, S_DWAIT = 3'd6;
  localparam int CW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  localparam int HW = $clog2(IRQ_HOLD + 1);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(DUMP_FIRST);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DUMP_LAST);

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      rcnt_q, rcnt_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d, daddr_q, daddr_d;
  logic [DATA_W-1:0]  ddata_q, ddata_d;
  logic               vld_q, vld_d, done_q, done_d, step_prev_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d, clr;
  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [IW-1:0]      id_q, id_d, sel;
  logic               launch;

  always_comb begin
    state_d = state_q;
    rcnt_d = rcnt_q;
    ptr_d = ptr_q;
    vld_d = vld_q;
    daddr_d = daddr_q;
    ddata_d = ddata_q;
    done_d = 1'b0;
    case (state_q)
      S_RST:   if (rcnt_q == CW'(RST_CYCLES - 1)) state_d = S_RUN; else rcnt_d = rcnt_q + CW'(1);
      S_RUN:   if (mode) state_d = S_HALT;
      S_HALT:  state_d = !mode ? S_RUN : dump_start ? S_DADDR : (step_req && !step_prev_q) ? S_STEP : S_HALT;
      S_STEP:  state_d = S_HALT;
      S_DADDR: state_d = S_DCAP;
      S_DCAP: begin
        ddata_d = debug_data;
        daddr_d = ptr_q;
        vld_d = 1'b1;
        state_d = S_DWAIT;
      end
      S_DWAIT: if (dump_ready) begin
        vld_d = 1'b0;
        done_d = ptr_q == LAST;
        ptr_d = ptr_q == LAST ? FIRST : ptr_q + ADDR_W'(1);
        state_d = ptr_q == LAST ? S_HALT : S_DADDR;
      end
      default: state_d = S_RST;
    endcase
  end

  // Lowest pending channel wins; a request arriving in the launch cycle survives the clear.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend_q[i]) sel = IW'(i);
    launch = hcnt_q == '0 && |pend_q;
    clr = launch ? NUM_IRQ'(1) << sel : '0;
    pend_d = state_q == S_RST ? '0 : (pend_q & ~clr) | irq_req;
    hcnt_d = launch ? HW'(IRQ_HOLD) : hcnt_q != '0 ? hcnt_q - HW'(1) : hcnt_q;
    id_d = launch ? sel : id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      rcnt_q <= '0;
      ptr_q <= FIRST;
      daddr_q <= '0;
      ddata_q <= '0;
      vld_q <= 1'b0;
      done_q <= 1'b0;
      step_prev_q <= 1'b0;
      pend_q <= '0;
      hcnt_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q <= rcnt_d;
      ptr_q <= ptr_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
      vld_q <= vld_d;
      done_q <= done_d;
      step_prev_q <= step_req;
      pend_q <= pend_d;
      hcnt_q <= hcnt_d;
      id_q <= id_d;
    end
  end

  assign core_rst = state_q == S_RST;
  assign debug_en = !(state_q == S_RST || state_q == S_RUN);
  assign debug_step = state_q == S_STEP;
  assign debug_addr = ptr_q;
  assign dump_valid = vld_q;
  assign dump_addr = daddr_q;
  assign dump_data = ddata_q;
  assign dump_done = done_q;
  assign interrupter = hcnt_q != '0;
  assign irq_id = id_q;
endmodule
